// File: rtl/mdu_if.sv
// Operand/command/result bundle for the iterative multiply/divide unit.
// master drives requests and operands; slave (the mdu) returns status and HI/LO.
interface mdu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mdcont;
    logic        start;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output a, b, mdcont, start, cancel,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  a, b, mdcont, start, cancel,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up applied when HI/LO commit.
module mdu (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_p;
    logic        neg_r;
    logic        bzero;
    logic        div0_r;
    logic [31:0] ra;
    logic [31:0] mcand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        st_sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [31:0] nx_hi;
    logic [31:0] nx_lo;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign st_sgn = ~bus.mdcont[0];
    assign abs_a  = (st_sgn && bus.a[31]) ? -bus.a : bus.a;
    assign abs_b  = (st_sgn && bus.b[31]) ? -bus.b : bus.b;

    // acc_lo holds the multiplier (multiply) or the dividend/quotient (divide)
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
        div_sh   = {acc_hi, acc_lo[31]};
        div_diff = div_sh - {1'b0, mcand};
        if (is_div) begin
            if (!div_diff[32]) begin
                nx_hi = div_diff[31:0];
                nx_lo = {acc_lo[30:0], 1'b1};
            end else begin
                nx_hi = div_sh[31:0];
                nx_lo = {acc_lo[30:0], 1'b0};
            end
        end else begin
            nx_hi = mul_sum[32:1];
            nx_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    always_comb begin
        prod   = neg_p ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (bzero) begin
                res_hi = ra;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -nx_hi : nx_hi;
                res_lo = neg_p ? -nx_lo : nx_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            bzero  <= 1'b0;
            div0_r <= 1'b0;
            ra     <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        case (bus.mdcont)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div <= bus.mdcont[1];
                                neg_p  <= st_sgn & (bus.a[31] ^ bus.b[31]);
                                neg_r  <= st_sgn & bus.a[31];
                                bzero  <= (bus.b == '0);
                                ra     <= bus.a;
                                mcand  <= abs_b;
                                acc_hi <= '0;
                                acc_lo <= abs_a;
                                cnt    <= '0;
                                state  <= CALC;
                            end
                            3'b100:  hi_r <= bus.a;
                            3'b101:  lo_r <= bus.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= nx_hi;
                        acc_lo <= nx_lo;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_r   <= res_hi;
                            lo_r   <= res_lo;
                            div0_r <= is_div & bzero;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    div0_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.div0 = (state == DONE) & div0_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: stimulus pushes expected HI/LO/div0 into a queue,
// an independent monitor pops and compares whenever done is presented.
module tb_mdu;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } exp_t;

    logic  clk;
    logic  reset;
    int    total;
    int    bad;
    exp_t  sbq[$];
    exp_t  mon_e;

    mdu_if bus ();

    mdu dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 required no pending operation");
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.name, " hi"}, bus.hi, mon_e.hi);
                    chk({mon_e.name, " lo"}, bus.lo, mon_e.lo);
                    chk({mon_e.name, " div0"}, {31'd0, bus.div0}, {31'd0, mon_e.d0});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic ed0, input bit noisy);
        int nbusy;
        int donecyc;
        nbusy   = 0;
        donecyc = 0;
        sbq.push_back('{name, ehi, elo, ed0});
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.mdcont = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = noisy;
        for (int c = 1; c <= 40 && donecyc == 0; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) donecyc = c;
            else if (noisy) begin
                bus.a      = $urandom;
                bus.b      = $urandom;
                bus.mdcont = 3'($urandom_range(0, 7));
            end
        end
        chk({name, " busy_cycles"}, 32'(nbusy), 32'd32);
        chk({name, " done_cycle"}, 32'(donecyc), 32'd33);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk({name, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({name, " idle_done"}, {31'd0, bus.done}, 32'd0);
        chk({name, " idle_div0"}, {31'd0, bus.div0}, 32'd0);
    endtask

    task automatic idle_cmd(input logic [2:0] op, input logic [31:0] a, input logic cancel);
        @(posedge clk); #1;
        bus.a = a; bus.mdcont = op; bus.start = 1'b1; bus.cancel = cancel;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dones;
        int wcyc;
        total = 0;
        bad   = 0;
        bus.a = '0; bus.b = '0; bus.mdcont = '0; bus.start = 1'b0; bus.cancel = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset div0", {31'd0, bus.div0}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op("mult_m3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("div_m7d2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_by0", 3'b011, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("divu_100d7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("div_neg_by0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("mult_min_sq", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_op("mult_5xm1", 3'b000, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0);
        run_op("div_7dm2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("multu_wide", 3'b001, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0, 1'b0);
        run_op("divu_noisy", 3'b011, 32'h1234, 32'h10, 32'h4, 32'h123, 1'b0, 1'b1);

        idle_cmd(3'b100, 32'h12345678, 1'b0);
        chk("mthi hi", bus.hi, 32'h12345678);
        chk("mthi busy", {31'd0, bus.busy}, 32'd0);
        idle_cmd(3'b101, 32'h9ABCDEF0, 1'b0);
        chk("mtlo lo", bus.lo, 32'h9ABCDEF0);
        chk("mtlo busy", {31'd0, bus.busy}, 32'd0);
        idle_cmd(3'b100, 32'hDEADBEEF, 1'b1);
        chk("mthi_cancelled hi", bus.hi, 32'h12345678);
        idle_cmd(3'b110, 32'h0BADF00D, 1'b0);
        idle_cmd(3'b111, 32'h0BADF00D, 1'b0);
        chk("noop hi", bus.hi, 32'h12345678);
        chk("noop lo", bus.lo, 32'h9ABCDEF0);
        chk("noop busy", {31'd0, bus.busy}, 32'd0);

        // MULT cancelled at CALC cycle 10
        @(posedge clk); #1;
        bus.a = 32'd3; bus.b = 32'd5; bus.mdcont = 3'b000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("cancel busy_before", {31'd0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel busy_after", {31'd0, bus.busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("cancel no_done", 32'(dones), 32'd0);
        chk("cancel hi", bus.hi, 32'h12345678);
        chk("cancel lo", bus.lo, 32'h9ABCDEF0);

        // cancel raised during DONE must not disturb the committed result
        sbq.push_back('{"multu_6x7", 32'd0, 32'd42, 1'b0});
        @(posedge clk); #1;
        bus.a = 32'd6; bus.b = 32'd7; bus.mdcont = 3'b001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wcyc = 0;
        while (bus.done !== 1'b1 && wcyc < 40) begin
            @(negedge clk);
            wcyc++;
        end
        chk("done_cancel done_cycle", 32'(wcyc), 32'd33);
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("done_cancel hi", bus.hi, 32'd0);
        chk("done_cancel lo", bus.lo, 32'd42);
        chk("done_cancel busy", {31'd0, bus.busy}, 32'd0);

        // asynchronous reset between edges at CALC cycle 20
        @(posedge clk); #1;
        bus.a = 32'hFFFFFFFF; bus.b = 32'd2; bus.mdcont = 3'b001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst done", {31'd0, bus.done}, 32'd0);
        chk("async_rst div0", {31'd0, bus.div0}, 32'd0);
        chk("async_rst hi", bus.hi, 32'd0);
        chk("async_rst lo", bus.lo, 32'd42 & 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- a  in  32  operand A: dividend, multiplicand, or MTHI/MTLO source.
- b  in  32  operand B: divisor or multiplier.
- mdcont  in  3  op code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- start  in  1  request; sampled only in IDLE.
- cancel  in  1  abort of the in-flight operation.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse; HI/LO are valid with the new result.
- div0  out  1  asserted with done when the completed op was DIV/DIVU with b=0.
- hi  out  32  HI register (product high word or remainder); read directly for MFHI.
- lo  out  32  LO register (product low word or quotient); read directly for MFLO.

Function
REQ-003 The FSM SHALL have states IDLE, CALC and DONE, plus a 5-bit iteration counter.
REQ-004 In IDLE with start=1, cancel=0 and mdcont in {000..011}:
- a, b and mdcont SHALL be latched.
- The counter SHALL be cleared.
- The next state SHALL be CALC.
REQ-005 In IDLE with start=1, cancel=0 and mdcont=100: hi SHALL take a at the next edge and the state SHALL remain IDLE. mdcont=101 SHALL do the same for lo.
REQ-006 In IDLE, start with mdcont 110/111 SHALL change nothing.
REQ-007 CALC SHALL last exactly 32 cycles (counter 0..31) and perform one iteration per cycle:
- multiply: shift-add.
- divide: restoring shift-subtract.
REQ-008 On the edge that leaves CALC with counter=31:
- hi/lo SHALL be written.
- The next state SHALL be DONE.
REQ-009 DONE SHALL last one cycle with done=1. It SHALL then return to IDLE.
REQ-010 Latency: start sampled at edge 0 -> busy=1 in cycles 1..32 -> done=1 in cycle 33.
REQ-011 busy SHALL be 1 only in CALC; done and div0 SHALL be 1 only in DONE.
REQ-012 start SHALL be ignored in CALC and DONE; it is not queued.
REQ-013 Changes on a, b or mdcont during CALC SHALL NOT affect the result.
REQ-014 MULTU SHALL produce the unsigned 64-bit product {hi,lo}.
REQ-015 MULT SHALL multiply operand magnitudes and two's-complement negate the 64-bit product when the operand signs differ.
REQ-016 DIVU SHALL produce lo = unsigned quotient and hi = unsigned remainder.
REQ-017 DIV SHALL divide magnitudes, then:
- negate the quotient when the operand signs differ;
- give the remainder the sign of the dividend.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0; it SHALL NOT raise a flag.
REQ-019 Divide by zero (either signedness) SHALL still take 32 CALC cycles and yield lo=0xFFFFFFFF, hi=a, div0=1 in DONE.
REQ-020 cancel=1 in CALC SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and no done pulse.
REQ-021 cancel=1 in DONE SHALL have no effect, because the result is already committed.
REQ-022 In IDLE, cancel=1 together with start=1 SHALL discard the start, including MTHI/MTLO.
REQ-023 hi/lo SHALL change only under REQ-005, REQ-008 and reset.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE and counter=0;
- busy=0, done=0, div0=0;
- hi=0, lo=0;
- all internal accumulators to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse. After release, the first start SHALL behave per REQ-010.
REQ-026 After reset deasserts, the block SHALL accept start at the first rising clk edge.

Verification
REQ-027 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIVU a=5, b=0 -> done with div0=1, lo=0xFFFFFFFF, hi=0x00000005. A following DIVU 100/7 -> lo=14, hi=2, div0=0.
REQ-030 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> hi/lo updated one edge after each start, with busy never high. Then MULT with cancel at cycle 10 -> FSM in IDLE, hi/lo still 0x12345678/0x9ABCDEF0, no done.
REQ-031 Start DIVU, then toggle a/b every cycle during CALC -> result matches the latched operands. Start pulses during CALC and DONE are ignored.
REQ-032 Assert reset asynchronously (between clock edges) at CALC cycle 20 -> all outputs 0 before the next edge. After release, MULTU 3*4 -> lo=12, hi=0 in cycle 33.
